compactor_diagnoser: RTL

Response-side diagnosis engine for the 16-bit ripple-adder scan compaction path. Per test pattern it takes the observed 6-bit compacted response and the tester's expected 6-bit value, and forms the syndrome `obs ^ exp`. It decodes the syndrome back to the single failing adder output (`sum[0..15]` or `co`), or classifies the pattern as a multi-bit fail. Failing patterns go into a small log FIFO that the test controller drains.

---
 rtl/compactor_diagnoser.sv | 121 ++++++++++++
 1 files changed

// File: rtl/compactor_diagnoser.sv
// compactor_diagnoser: decodes compacted-response syndromes to a failing adder bit and logs fails in a FIFO
module compactor_diagnoser #(
  parameter int PCNT_W    = 16,
  parameter int LOG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [5:0]        obs,
  input  logic [5:0]        exp,
  output logic              log_valid,
  input  logic              log_ready,
  output logic [PCNT_W-1:0] log_pat,
  output logic [1:0]        log_kind,
  output logic [4:0]        log_loc,
  output logic [5:0]        log_syn,
  output logic [PCNT_W-1:0] pat_cnt,
  output logic [PCNT_W-1:0] fail_cnt,
  output logic [PCNT_W-1:0] multi_cnt,
  output logic              done
);
  localparam int AW = $clog2(LOG_DEPTH);
  localparam int EW = PCNT_W + 13;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t              state;
  logic                s1_valid, s1_last;
  logic [5:0]          s1_syn;
  logic [PCNT_W-1:0]   s1_pat;
  logic [EW-1:0]       mem [LOG_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         count;
  logic [4:0]          loc;
  logic                single, push, pop, accept;
  always_comb begin
    case (s1_syn)
      6'h07: loc = 5'd0;
      6'h23: loc = 5'd1;
      6'h31: loc = 5'd2;
      6'h38: loc = 5'd3;
      6'h2A: loc = 5'd4;
      6'h26: loc = 5'd5;
      6'h1C: loc = 5'd6;
      6'h15: loc = 5'd7;
      6'h19: loc = 5'd8;
      6'h29: loc = 5'd9;
      6'h1A: loc = 5'd10;
      6'h34: loc = 5'd11;
      6'h2C: loc = 5'd12;
      6'h25: loc = 5'd13;
      6'h16: loc = 5'd14;
      6'h0B: loc = 5'd15;
      6'h13: loc = 5'd16;
      default: loc = 5'd31;
    endcase
  end
  assign single    = loc != 5'd31;
  assign push      = s1_valid && s1_syn != 6'd0;
  assign log_valid = count != '0;
  assign pop       = log_valid && log_ready;
  // stage 1 is counted as occupied so a decoded fail always has a FIFO slot
  assign in_ready  = (state == IDLE || state == RUN) &&
                     ({1'b0, count} + (AW+2)'(s1_valid) < (AW+2)'(LOG_DEPTH));
  assign accept    = in_valid && in_ready;
  assign {log_pat, log_kind, log_loc, log_syn} = log_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {s1_pat, single ? 2'b01 : 2'b10, loc, s1_syn};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      done      <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_syn    <= '0;
      s1_pat    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pat_cnt   <= '0;
      fail_cnt  <= '0;
      multi_cnt <= '0;
    end else if (clear) begin
      state     <= IDLE;
      done      <= 1'b0;
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_syn    <= '0;
      s1_pat    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pat_cnt   <= '0;
      fail_cnt  <= '0;
      multi_cnt <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_syn  <= obs ^ exp;
        s1_pat  <= pat_cnt;
        s1_last <= in_last;
      end
      if (accept && pat_cnt != '1) pat_cnt <= pat_cnt + 1'b1;
      if (push && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      if (push && !single && multi_cnt != '1) multi_cnt <= multi_cnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      case (state)
        IDLE:  if (accept) state <= in_last ? DRAIN : RUN;
        RUN:   if (accept && in_last) state <= DRAIN;
        DRAIN: if (!(s1_valid && s1_last)) begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
